// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding select and load-use hazard
// stall control for a classic five-stage pipeline.
//
// Optional feature: define FWD_HAZARD_STALL_CNT_EN to add the 16-bit
// saturating stall_cnt statistics counter and its output port.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_src            ID-stage source addresses, slot i at [i*REG_AW +: REG_AW]
//   id_src_used       per-slot valid for id_src
//   id_ex_src         EX-stage source addresses, same packing as id_src
//   id_ex_memread     EX-stage instruction is a load
//   id_ex_rd          EX-stage destination register
//   ex_mem_rw/_rd     MEM-stage write enable / destination
//   mem_wb_rw/_rd     WB-stage write enable / destination
//   fwd_sel           per-slot EX mux select at [2i +: 2]:
//                     10 = EX/MEM, 01 = MEM/WB, 00 = register file
//   pc_write          PC update enable
//   if_id_write       IF/ID register update enable
//   id_ex_flush       insert a bubble into ID/EX
//   stall_cnt         count of stalled cycles (FWD_HAZARD_STALL_CNT_EN only)
//
// The stall controls are combinational from the current state and the ID
// inputs, since the bubble has to be inserted in the same cycle the hazard
// is seen.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned LOAD_STALL_CYC = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0]   id_ex_src,
  input  logic                        id_ex_memread,
  input  logic [REG_AW-1:0]           id_ex_rd,
  input  logic                        ex_mem_rw,
  input  logic [REG_AW-1:0]           ex_mem_rd,
  input  logic                        mem_wb_rw,
  input  logic [REG_AW-1:0]           mem_wb_rd,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic                        pc_write,
  output logic                        if_id_write,
  output logic                        id_ex_flush
`ifdef FWD_HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  // Bubbles still owed after the hazard cycle itself, minus one (the
  // STALL state exits when the counter reaches zero).
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LOAD_STALL_CYC > 1) ? CNT_W'(LOAD_STALL_CYC - 2) : '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard_c;
  logic             ex_mem_fwd_ok_c;
  logic             mem_wb_fwd_ok_c;
  logic             load_ok_c;

  // Register 0 is hard-wired zero and never a forwarding or hazard source.
  assign ex_mem_fwd_ok_c = ex_mem_rw && (ex_mem_rd != '0);
  assign mem_wb_fwd_ok_c = mem_wb_rw && (mem_wb_rd != '0);
  assign load_ok_c       = id_ex_memread && (id_ex_rd != '0);

  // Forwarding select; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (ex_mem_fwd_ok_c && (ex_mem_rd == id_ex_src[i*REG_AW +: REG_AW])) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end else if (mem_wb_fwd_ok_c && (mem_wb_rd == id_ex_src[i*REG_AW +: REG_AW])) begin
        fwd_sel[2*i +: 2] = 2'b01;
      end
    end
  end

  // Load-use hazard: any used ID source reads the register the load in EX
  // is about to write.
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == id_ex_rd)) begin
        hazard_c = 1'b1;
      end
    end
    hazard_c = hazard_c && load_ok_c;
  end

  // Stall FSM next-state and control outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hazard_c) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_STALL_CYC > 1) begin
            state_d = ST_STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_STALL: begin
        // Hazard input is ignored until the current sequence completes.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {STAT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances (LOAD_STALL_CYC 1 and 3)
// share one stimulus stream. The driver pushes expected outputs computed by a
// bubble-count reference model; a negedge monitor pops and compares.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  id_src = '0;
  logic [1:0]  id_src_used = '0;
  logic [9:0]  id_ex_src = '0;
  logic        id_ex_memread = 1'b0;
  logic [4:0]  id_ex_rd = '0;
  logic        ex_mem_rw = 1'b0;
  logic [4:0]  ex_mem_rd = '0;
  logic        mem_wb_rw = 1'b0;
  logic [4:0]  mem_wb_rd = '0;

  logic [3:0]  fwd_sel1, fwd_sel3;
  logic        pc_write1, pc_write3;
  logic        if_id_write1, if_id_write3;
  logic        flush1, flush3;
`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt1, stall_cnt3;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .id_ex_src(id_ex_src), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_mem_rw(ex_mem_rw), .ex_mem_rd(ex_mem_rd), .mem_wb_rw(mem_wb_rw),
    .mem_wb_rd(mem_wb_rd), .fwd_sel(fwd_sel1), .pc_write(pc_write1),
    .if_id_write(if_id_write1), .id_ex_flush(flush1)
`ifdef FWD_HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL_CYC(3)) u3 (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .id_ex_src(id_ex_src), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_mem_rw(ex_mem_rw), .ex_mem_rd(ex_mem_rd), .mem_wb_rw(mem_wb_rw),
    .mem_wb_rd(mem_wb_rd), .fwd_sel(fwd_sel3), .pc_write(pc_write3),
    .if_id_write(if_id_write3), .id_ex_flush(flush3)
`ifdef FWD_HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  typedef struct {
    int          id;
    logic [3:0]  fwd;
    logic        st1;
    logic        st3;
    logic [15:0] sc1;
    logic [15:0] sc3;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pushed = 0;
  int   popped = 0;
  int   step_id = 0;

  // Reference model state: bubbles still owed after the current cycle.
  int   left1 = 0;
  int   left3 = 0;
  int   sc1 = 0;
  int   sc3 = 0;

  task automatic check(input string name, input int id,
                       input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, id, act, exp);
    end
  endtask

  // Per slot: nearest producer that writes a non-zero register wins.
  function automatic logic [3:0] ref_fwd();
    logic [3:0] r;
    logic [4:0] s;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      s = id_ex_src[k*5 +: 5];
      if (s != 0) begin
        if (ex_mem_rw && ex_mem_rd == s)      r[2*k +: 2] = 2'd2;
        else if (mem_wb_rw && mem_wb_rd == s) r[2*k +: 2] = 2'd1;
      end
    end
    return r;
  endfunction

  function automatic logic ref_hazard();
    logic h;
    h = 1'b0;
    if (id_ex_memread && id_ex_rd != 0)
      for (int k = 0; k < 2; k++)
        if (id_src_used[k] && id_src[k*5 +: 5] == id_ex_rd) h = 1'b1;
    return h;
  endfunction

  // Apply one cycle of inputs shortly after the rising edge and push the
  // outputs expected for that cycle.
  task automatic drive(input logic rst, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] used, input logic [4:0] x1, input logic [4:0] x0,
                       input logic mr, input logic [4:0] exrd,
                       input logic emw, input logic [4:0] emrd,
                       input logic mww, input logic [4:0] mwrd);
    exp_t e;
    logic hz;
    @(posedge clk);
    #1;
    rst_n = rst;
    id_src = {s1, s0};
    id_src_used = used;
    id_ex_src = {x1, x0};
    id_ex_memread = mr;
    id_ex_rd = exrd;
    ex_mem_rw = emw;
    ex_mem_rd = emrd;
    mem_wb_rw = mww;
    mem_wb_rd = mwrd;
    if (!rst) begin
      left1 = 0; left3 = 0; sc1 = 0; sc3 = 0;
    end
    hz = ref_hazard();
    e.id  = step_id;
    e.fwd = ref_fwd();
    e.st1 = (left1 > 0) || hz;
    e.st3 = (left3 > 0) || hz;
    e.sc1 = 16'(sc1);
    e.sc3 = 16'(sc3);
    q.push_back(e);
    pushed++;
    step_id++;
    if (rst) begin
      if (left1 > 0) left1--; else if (hz) left1 = 0;
      if (left3 > 0) left3--; else if (hz) left3 = 2;
      if (e.st1 && sc1 < 65535) sc1++;
      if (e.st3 && sc3 < 65535) sc3++;
    end
  endtask

  task automatic idle(input logic rst);
    drive(rst, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  function automatic logic [4:0] ra();
    return 5'($urandom_range(0, 7));
  endfunction

  // Monitor: compare whatever the driver queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      popped++;
      check("fwd_sel_u1", e.id, 16'(fwd_sel1), 16'(e.fwd));
      check("fwd_sel_u3", e.id, 16'(fwd_sel3), 16'(e.fwd));
      check("pc_write_u1", e.id, 16'(pc_write1), 16'(!e.st1));
      check("if_id_write_u1", e.id, 16'(if_id_write1), 16'(!e.st1));
      check("flush_u1", e.id, 16'(flush1), 16'(e.st1));
      check("pc_write_u3", e.id, 16'(pc_write3), 16'(!e.st3));
      check("if_id_write_u3", e.id, 16'(if_id_write3), 16'(!e.st3));
      check("flush_u3", e.id, 16'(flush3), 16'(e.st3));
`ifdef FWD_HAZARD_STALL_CNT_EN
      check("stall_cnt_u1", e.id, stall_cnt1, e.sc1);
      check("stall_cnt_u3", e.id, stall_cnt3, e.sc3);
`endif
    end
  end

  initial begin
    // Reset state.
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    // EX/MEM has priority over MEM/WB on both slots.
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3);
    // MEM/WB forward on slot 1 only.
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    // Register 0 never forwards.
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    // Load-use on slot 0, then idle to observe stall length.
    drive(1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (4) idle(1'b1);
    // Same addresses but slot unused: no stall.
    drive(1'b1, 5'd0, 5'd5, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) idle(1'b1);
    // Hazard pulse, then reset during the second stall cycle.
    drive(1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    idle(1'b0);
    repeat (3) idle(1'b1);
    // Persistent hazard: new sequence starts right after each one ends.
    repeat (8) drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) idle(1'b1);
    // Load into register 0 never stalls.
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle(1'b1);
    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) != 0), ra(), ra(), 2'($urandom_range(0, 3)),
            ra(), ra(), ($urandom_range(0, 2) == 0), ra(),
            1'($urandom_range(0, 1)), ra(), 1'($urandom_range(0, 1)), ra());
    end
    idle(1'b1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", step_id, 16'(q.size()), 16'(0));
    check("scoreboard_count", step_id, 16'(popped), 16'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
